// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA timing generator with frame-buffer read
// requests and latency-aligned colour/sync outputs.
// Optional 2x pixel/line replication is compiled in when VGA_SCALE_EN is defined;
// without it scale_mode is ignored and the core always runs 1x.
module vga_timing_core #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int H_SIZE      = 10,
   parameter int V_SIZE      = 10,
   parameter int RSIZE       = 4,
   parameter int GSIZE       = 4,
   parameter int BSIZE       = 4,
   parameter int RGB_SIZE    = RSIZE + GSIZE + BSIZE,
   parameter int START_DELAY = 0,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_POL    = 0
) (
   input  logic                pixel_clk,
   input  logic                pixel_rst,
   input  logic                vga_start,
   input  logic                scale_mode,
   output logic                vga_read,
   output logic [H_SIZE-1:0]   vga_read_x,
   output logic [V_SIZE-1:0]   vga_read_y,
   input  logic [RGB_SIZE-1:0] vga_rgb,
   output logic                line_start,
   output logic                frame_start,
   output logic [RSIZE-1:0]    vga_r,
   output logic [GSIZE-1:0]    vga_g,
   output logic [BSIZE-1:0]    vga_b,
   output logic                vga_hsync,
   output logic                vga_vsync
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Window bounds are compared one bit wider so an end bound equal to the
   // counter range cannot wrap.
   localparam logic [H_SIZE-1:0] C_H_LAST   = H_SIZE'(H_TOTAL - 1);
   localparam logic [V_SIZE-1:0] C_V_LAST   = V_SIZE'(V_TOTAL - 1);
   localparam logic [H_SIZE-1:0] C_WIN_BEG  = H_SIZE'(START_DELAY);
   localparam logic [H_SIZE:0]   C_WIN_END  = (H_SIZE+1)'(START_DELAY + H_DISPLAY);
   localparam logic [H_SIZE:0]   C_HS_BEG   = (H_SIZE+1)'(H_DISPLAY + H_FRONT);
   localparam logic [H_SIZE:0]   C_HS_END   = (H_SIZE+1)'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [V_SIZE:0]   C_V_DISP   = (V_SIZE+1)'(V_DISPLAY);
   localparam logic [V_SIZE:0]   C_VS_BEG   = (V_SIZE+1)'(V_DISPLAY + V_FRONT);
   localparam logic [V_SIZE:0]   C_VS_END   = (V_SIZE+1)'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic              C_SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

   if (START_DELAY + H_DISPLAY > H_TOTAL) begin : g_bad_window
      $error("vga_timing_core: START_DELAY + H_DISPLAY exceeds H_TOTAL");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
      $error("vga_timing_core: RD_LATENCY must be 1..8");
   end

   logic                w_en;
   logic                w_clr;
   logic [H_SIZE-1:0]   r_h_count;
   logic [V_SIZE-1:0]   r_v_count;
   logic                w_line_start;
   logic                w_frame_start;
   logic                w_von;
   logic                w_hs_act;
   logic                w_vs_act;
   logic [H_SIZE-1:0]   w_col;
   logic                w_rd;
   logic [H_SIZE-1:0]   w_rx;
   logic [V_SIZE-1:0]   w_ry;
   logic [RGB_SIZE-1:0] w_pix;
   logic [RD_LATENCY-1:0] r_von_pipe;
   logic [RD_LATENCY-1:0] r_hs_pipe;
   logic [RD_LATENCY-1:0] r_vs_pipe;
   logic [RGB_SIZE-1:0] r_rgb;
   logic                r_hsync;
   logic                r_vsync;

   assign w_en  = vga_start & ~pixel_rst;
   assign w_clr = ~w_en;

   // Horizontal/vertical raster counters; held at zero while disabled.
   always_ff @(posedge pixel_clk) begin
      if (w_clr) begin
         r_h_count <= '0;
         r_v_count <= '0;
      end else if (r_h_count == C_H_LAST) begin
         r_h_count <= '0;
         r_v_count <= (r_v_count == C_V_LAST) ? '0 : r_v_count + 1'b1;
      end else begin
         r_h_count <= r_h_count + 1'b1;
      end
   end

   assign w_line_start  = w_en & (r_h_count == '0);
   assign w_frame_start = w_line_start & (r_v_count == '0);
   assign w_von    = w_en & (r_h_count >= C_WIN_BEG) & ({1'b0, r_h_count} < C_WIN_END)
                     & ({1'b0, r_v_count} < C_V_DISP);
   assign w_hs_act = w_en & ({1'b0, r_h_count} >= C_HS_BEG) & ({1'b0, r_h_count} < C_HS_END);
   assign w_vs_act = w_en & ({1'b0, r_v_count} >= C_VS_BEG) & ({1'b0, r_v_count} < C_VS_END);
   assign w_col    = r_h_count - C_WIN_BEG;

`ifdef VGA_SCALE_EN
   logic                  r_mode;
   logic                  w_mode;
   logic [RD_LATENCY-1:0] r_rd_pipe;
   logic [RGB_SIZE-1:0]   r_hold;

   // Mode only changes at a frame boundary; the first enabled cycle after
   // reset is always a frame_start, which covers the reset-exit sample.
   always_ff @(posedge pixel_clk) begin
      if (w_clr) r_mode <= 1'b0;
      else if (w_frame_start) r_mode <= scale_mode;
   end

   // On the frame_start cycle itself the new mode already governs pixel (0,0).
   assign w_mode = w_frame_start ? scale_mode : r_mode;

   // Read request and source coordinates, halved in 2x mode.
   always_comb begin
      w_rd = w_von & ~(w_mode & w_col[0]);
      w_rx = w_mode ? (w_col >> 1) : w_col;
      w_ry = w_mode ? (r_v_count >> 1) : r_v_count;
   end

   // Track which pipeline slots carry real read data, and hold that data so
   // the odd pixel of a pair can replay it.
   always_ff @(posedge pixel_clk) begin
      if (w_clr) begin
         r_rd_pipe <= '0;
         r_hold    <= '0;
      end else begin
         r_rd_pipe[0] <= w_rd;
         for (int i = 1; i < RD_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
         if (r_rd_pipe[RD_LATENCY-1]) r_hold <= vga_rgb;
      end
   end

   assign w_pix = r_rd_pipe[RD_LATENCY-1] ? vga_rgb : r_hold;
`else
   logic w_unused_scale;
   assign w_unused_scale = scale_mode;

   // Read request and source coordinates, always 1x.
   always_comb begin
      w_rd = w_von;
      w_rx = w_col;
      w_ry = r_v_count;
   end

   assign w_pix = vga_rgb;
`endif

   assign vga_read    = w_rd;
   assign vga_read_x  = w_rd ? w_rx : '0;
   assign vga_read_y  = w_rd ? w_ry : '0;
   assign line_start  = w_line_start;
   assign frame_start = w_frame_start;

   // Delay video_on and sync state to line up with returned read data.
   always_ff @(posedge pixel_clk) begin
      if (w_clr) begin
         r_von_pipe <= '0;
         r_hs_pipe  <= '0;
         r_vs_pipe  <= '0;
      end else begin
         r_von_pipe[0] <= w_von;
         r_hs_pipe[0]  <= w_hs_act;
         r_vs_pipe[0]  <= w_vs_act;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_von_pipe[i] <= r_von_pipe[i-1];
            r_hs_pipe[i]  <= r_hs_pipe[i-1];
            r_vs_pipe[i]  <= r_vs_pipe[i-1];
         end
      end
   end

   // Registered pin stage: colour blanked outside the window, syncs polarised.
   always_ff @(posedge pixel_clk) begin
      if (w_clr) begin
         r_rgb   <= '0;
         r_hsync <= C_SYNC_IDLE;
         r_vsync <= C_SYNC_IDLE;
      end else begin
         r_rgb   <= r_von_pipe[RD_LATENCY-1] ? w_pix : '0;
         r_hsync <= r_hs_pipe[RD_LATENCY-1] ^ C_SYNC_IDLE;
         r_vsync <= r_vs_pipe[RD_LATENCY-1] ^ C_SYNC_IDLE;
      end
   end

   assign vga_r     = r_rgb[RGB_SIZE-1 -: RSIZE];
   assign vga_g     = r_rgb[GSIZE+BSIZE-1 -: GSIZE];
   assign vga_b     = r_rgb[BSIZE-1:0];
   assign vga_hsync = r_hsync;
   assign vga_vsync = r_vsync;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core on a reduced 16x10 raster
// (display 8x6, START_DELAY 2, RD_LATENCY 3, active-low syncs).
module tb_vga_timing_core;

`ifdef VGA_SCALE_EN
   localparam bit SCALE = 1'b1;
`else
   localparam bit SCALE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        smode;
   logic        rd;
   logic [4:0]  rx;
   logic [4:0]  ry;
   logic [11:0] rgb_in;
   logic        ls, fs;
   logic [3:0]  r, g, b;
   logic        hs, vs;
   logic [11:0] q1 = '0, q2 = '0, q3 = '0;
   int          n_pass = 0;
   int          n_total = 0;
   int          c = 0;

   always #5 clk = ~clk;

   vga_timing_core #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SIZE(5), .V_SIZE(5), .RSIZE(4), .GSIZE(4), .BSIZE(4), .RGB_SIZE(12),
      .START_DELAY(2), .RD_LATENCY(3), .SYNC_POL(0)
   ) dut (
      .pixel_clk(clk), .pixel_rst(rst), .vga_start(start), .scale_mode(smode),
      .vga_read(rd), .vga_read_x(rx), .vga_read_y(ry), .vga_rgb(rgb_in),
      .line_start(ls), .frame_start(fs),
      .vga_r(r), .vga_g(g), .vga_b(b), .vga_hsync(hs), .vga_vsync(vs)
   );

   function automatic logic [11:0] f(input logic [4:0] x, input logic [4:0] y);
      return {y[3:0], 3'b101, x};
   endfunction

   // Frame-buffer model: 3-cycle read latency, junk when no read is pending.
   always @(posedge clk) begin
      q1 <= rd ? f(rx, ry) : 12'hABC;
      q2 <= q1;
      q3 <= q2;
   end
   assign rgb_in = q3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic go(input int t);
      while (c < t) begin
         @(negedge clk);
         c++;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; smode = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_read", rd, 0);
      chk("rst_hsync", hs, 1);
      chk("rst_vsync", vs, 1);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_ls", ls, 0);
      chk("rst_fs", fs, 0);

      rst = 1'b0; c = 0; #1;
      chk("c0_fs", fs, 1);
      chk("c0_ls", ls, 1);
      chk("c0_read", rd, 0);
      go(2);   chk("c2_read", rd, 1); chk("c2_x", rx, 0); chk("c2_y", ry, 0);
      go(5);   chk("c5_rgb_blank", {r, g, b}, 0);
      go(6);   chk("c6_rgb", {r, g, b}, f(0, 0));
      go(9);   chk("c9_read", rd, 1); chk("c9_x", rx, 7);
      go(10);  chk("c10_read", rd, 0); chk("c10_x", rx, 0);
      go(13);  chk("c13_rgb", {r, g, b}, f(7, 0)); chk("c13_hs", hs, 1);
      go(14);  chk("c14_rgb", {r, g, b}, 0); chk("c14_hs", hs, 0);
      go(16);  chk("c16_hs", hs, 0); chk("c16_ls", ls, 1); chk("c16_fs", fs, 0);
      go(17);  chk("c17_hs", hs, 1);
      go(18);  chk("c18_read", rd, 1); chk("c18_x", rx, 0); chk("c18_y", ry, 1);
      go(20);  smode = 1'b1;
      go(35);  chk("c35_read", rd, 1); chk("c35_x", rx, 1); chk("c35_y", ry, 2);
      go(39);  chk("c39_rgb", {r, g, b}, f(1, 2));
      go(82);  chk("c82_read", rd, 1); chk("c82_y", ry, 5);
      go(98);  chk("c98_read", rd, 0);
      go(115); chk("c115_vs", vs, 1);
      go(116); chk("c116_vs", vs, 0);
      go(147); chk("c147_vs", vs, 0);
      go(148); chk("c148_vs", vs, 1);
      go(159); chk("c159_fs", fs, 0);
      go(160); chk("c160_fs", fs, 1);
      go(162); chk("f1_c162_read", rd, 1); chk("f1_c162_x", rx, 0); chk("f1_c162_y", ry, 0);
      go(163); chk("f1_c163_read", rd, SCALE ? 0 : 1); chk("f1_c163_x", rx, SCALE ? 0 : 1);
      go(164); chk("f1_c164_read", rd, 1); chk("f1_c164_x", rx, SCALE ? 1 : 2);
      go(166); chk("f1_c166_rgb", {r, g, b}, f(0, 0));
      go(167); chk("f1_c167_rgb", {r, g, b}, SCALE ? f(0, 0) : f(1, 0));
      go(168); chk("f1_c168_rgb", {r, g, b}, SCALE ? f(1, 0) : f(2, 0));
      go(178); chk("f1_line1_y", ry, SCALE ? 0 : 1);
      go(194); chk("f1_line2_y", ry, SCALE ? 1 : 2);
      go(212); smode = 1'b0;
      go(227); chk("f1_line4_odd_read", rd, SCALE ? 0 : 1);
      go(320); chk("f2_fs", fs, 1);
      go(323); chk("f2_c323_read", rd, 1); chk("f2_c323_x", rx, 1);
      go(445); chk("pre_drop_vs", vs, 0); chk("pre_drop_hs", hs, 1);
      start = 1'b0;
      go(446); chk("drop_vs", vs, 1); chk("drop_read", rd, 0); chk("drop_rgb", {r, g, b}, 0);
      go(455);
      start = 1'b1; c = 0; #1;
      chk("restart_fs", fs, 1);
      chk("restart_ls", ls, 1);
      go(1);   chk("restart_c1_fs", fs, 0);
      go(2);   chk("restart_c2_read", rd, 1); chk("restart_c2_x", rx, 0); chk("restart_c2_y", ry, 0);
      go(4);   chk("restart_c4_vs", vs, 1); chk("restart_c4_hs", hs, 1); chk("restart_c4_rgb", {r, g, b}, 0);
      go(6);   chk("restart_c6_rgb", {r, g, b}, f(0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
